ingress_bundle_fifo: RTL and testbench
======================================

INGRESS_BUNDLE_FIFO -- requirements
Module: ingress_bundle_fifo

Interface
REQ-001 The block SHALL have parameter Depth, default 8, meaning the number of retirement bundles stored; it SHALL be a power of two and at least 2.
REQ-002 The block SHALL use package constant mure_pkg::NrRetiredInstr, value 4, meaning the retirement slots per bundle.
REQ-003 The block SHALL have port clk_i, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst_ni, input, 1 bit: reset, asynchronous and active-low.
REQ-005 The block SHALL have port valids_i, input, NrRetiredInstr bits: per-slot retirement valids from the commit port; bit NrRetiredInstr-1 is slot A.
REQ-006 The block SHALL have port uops_i, input, NrRetiredInstr x mure_pkg::uop_entry_s: commit-port uop entries; element 0 is A.
REQ-007 The block SHALL have port flush_i, input, 1 bit: synchronous clear of the buffer contents.
REQ-008 The block SHALL have port pop_i, input, 1 bit: consumer (ingress_fsm) releases the head bundle.
REQ-009 The block SHALL have port ivalids_o, output, NrRetiredInstr bits: head bundle valids.
REQ-010 The block SHALL have ports uop_a_o, uop_b_o, uop_c_o and uop_d_o, outputs, mure_pkg::uop_entry_s each: head bundle entries.
REQ-011 The block SHALL have ports empty_o and full_o, outputs, 1 bit each: occupancy flags.
REQ-012 The block SHALL have port count_o, output, $clog2(Depth+1) bits: stored bundle count.
REQ-013 The block SHALL have port overflow_o, output, 1 bit: sticky flag, set when a bundle was dropped.

Function
REQ-014 A push SHALL occur in a cycle exactly when valids_i != 0; all-zero valids SHALL never be stored.
REQ-015 A push SHALL store valids_i and all four uops_i entries unmodified as one bundle at the tail.
REQ-016 The FIFO SHALL be first-word-fall-through: a stored bundle SHALL appear on the head outputs the cycle after its push edge, with no push-to-output combinational path.
REQ-017 While empty_o=1, ivalids_o and all uop_*_o outputs SHALL be all-zero.
REQ-018 A pop SHALL occur when pop_i=1 and empty_o=0; the next bundle SHALL appear on the head outputs the following cycle.
REQ-019 A pop_i asserted while empty SHALL be ignored, with no pointer or count change.
REQ-020 A push in a cycle where full_o=1 and pop_i=1 SHALL be accepted, leaving count unchanged.
REQ-021 A push in a cycle where full_o=1 and pop_i=0 SHALL be dropped, set overflow_o, and leave contents unchanged.
REQ-022 A simultaneous push and pop while not full SHALL leave count unchanged and advance both pointers.
REQ-023 A simultaneous push and pop while count=1 SHALL present the new bundle on the head outputs the next cycle.
REQ-024 Read and write pointers SHALL wrap modulo Depth; count SHALL never exceed Depth or go below 0.
REQ-025 empty_o SHALL equal (count=0) and full_o SHALL equal (count=Depth), both registered-derived with no input dependency.
REQ-026 flush_i=1 SHALL reset the pointers and count to 0 at the next edge, and SHALL override any push or pop in the same cycle.
REQ-027 overflow_o SHALL stay set until reset or flush.
REQ-028 Storage contents SHALL be don't-care after a flush and SHALL never be visible while empty.

Reset
REQ-029 Asserting rst_ni low SHALL immediately clear the pointers and count and set empty_o=1, full_o=0, count_o=0, overflow_o=0, ivalids_o=0 and all uop_*_o outputs to 0.
REQ-030 Reset asserted mid-operation SHALL discard all stored bundles; the first push after release SHALL behave as a push into an empty FIFO.
REQ-031 Storage array contents SHALL not require reset.

Structure
REQ-032 The types NrRetiredInstr, uop_entry_s and itype_e SHALL reside in mure_pkg; the block SHALL add no new types.
REQ-033 The block SHALL be a single module with no sub-modules; pointer and count logic SHALL be in one always_ff with an asynchronous reset and storage in a separate always_ff without reset.

Verification
REQ-034 The bench SHALL cover this scenario: after reset, push valids=4'b1100 with A.itype=STD -> the next cycle shows ivalids_o=4'b1100 and count_o=1; pop -> the next cycle shows empty_o=1 and outputs zero.
REQ-035 The bench SHALL cover this scenario: 8 consecutive pushes with Depth=8 -> full_o=1; a 9th push without pop -> the bundle is dropped, overflow_o=1 and the head is unchanged.
REQ-036 The bench SHALL cover this scenario: while full, push together with pop -> count_o stays 8 and the pushed bundle is read back 8th.
REQ-037 The bench SHALL cover this scenario: valids_i=4'b0000 for 5 cycles -> count_o stays 0 and empty_o stays 1.
REQ-038 The bench SHALL cover this scenario: 3 bundles stored, then flush_i with pop_i and a push in the same cycle -> the next cycle shows count_o=0, empty_o=1 and overflow_o=0.
REQ-039 The bench SHALL cover this scenario: 20 random push/pop cycles crossing pointer wrap, with rst_ni pulsed low asynchronously mid-run -> order is preserved against a reference queue and all outputs are zero immediately on reset.

Source files
------------

// File: rtl/mure_pkg.sv
// Shared retirement types: slot count, instruction class and the per-slot uop entry
// carried from the commit port into the ingress path.
package mure_pkg;

  localparam int unsigned NrRetiredInstr = 4;

  typedef enum logic [2:0] {
    ITYPE_NONE = 3'd0,
    ALU        = 3'd1,
    MUL        = 3'd2,
    LOAD       = 3'd3,
    STD        = 3'd4,
    BRANCH     = 3'd5,
    CSR        = 3'd6
  } itype_e;

  typedef struct packed {
    logic [31:0] pc;
    itype_e      itype;
    logic [4:0]  rd;
  } uop_entry_s;

  localparam uop_entry_s UopZero = '{pc: 32'd0, itype: ITYPE_NONE, rd: 5'd0};

endpackage

// File: rtl/ingress_bundle_fifo.sv
// First-word-fall-through FIFO of retirement bundles (valids plus four uop entries);
// all-zero valid cycles are never stored and the head reads as zero while empty.
module ingress_bundle_fifo
  import mure_pkg::*;
#(
  parameter int unsigned Depth = 8
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
  input  logic [NrRetiredInstr-1:0]           valids_i,
  input  uop_entry_s [NrRetiredInstr-1:0]     uops_i,
  input  logic                                flush_i,
  input  logic                                pop_i,
  output logic [NrRetiredInstr-1:0]           ivalids_o,
  output uop_entry_s                          uop_a_o,
  output uop_entry_s                          uop_b_o,
  output uop_entry_s                          uop_c_o,
  output uop_entry_s                          uop_d_o,
  output logic                                empty_o,
  output logic                                full_o,
  output logic [$clog2(Depth+1)-1:0]          count_o,
  output logic                                overflow_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = $clog2(Depth + 1);
  localparam logic [CntW-1:0] DepthCnt = CntW'(Depth);

  logic [PtrW-1:0] wr_ptr_r;
  logic [PtrW-1:0] rd_ptr_r;
  logic [CntW-1:0] count_r;
  logic            overflow_r;

  logic            push_s;
  logic            pop_s;
  logic            wr_en_s;
  logic            drop_s;
  logic            empty_s;
  logic            full_s;

  logic [NrRetiredInstr-1:0]       valid_mem_r [Depth];
  uop_entry_s [NrRetiredInstr-1:0] uop_mem_r   [Depth];

  // Handshake decode; a full FIFO still accepts a push when the head leaves the same cycle.
  always_comb begin
    push_s  = |valids_i;
    empty_s = (count_r == {CntW{1'b0}});
    full_s  = (count_r == DepthCnt);
    pop_s   = pop_i & ~empty_s & ~flush_i;
    wr_en_s = push_s & (~full_s | pop_s) & ~flush_i;
    drop_s  = push_s & full_s & ~pop_s & ~flush_i;
  end

  // Pointer, occupancy and sticky-overflow state; flush wins over push and pop.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_r   <= {PtrW{1'b0}};
      rd_ptr_r   <= {PtrW{1'b0}};
      count_r    <= {CntW{1'b0}};
      overflow_r <= 1'b0;
    end else if (flush_i) begin
      wr_ptr_r   <= {PtrW{1'b0}};
      rd_ptr_r   <= {PtrW{1'b0}};
      count_r    <= {CntW{1'b0}};
      overflow_r <= 1'b0;
    end else begin
      if (wr_en_s) begin
        wr_ptr_r <= wr_ptr_r + PtrW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PtrW'(1);
      end
      case ({wr_en_s, pop_s})
        2'b10:   count_r <= count_r + CntW'(1);
        2'b01:   count_r <= count_r - CntW'(1);
        default: count_r <= count_r;
      endcase
      if (drop_s) begin
        overflow_r <= 1'b1;
      end
    end
  end

  // Bundle storage; contents are only ever observed through a non-empty head.
  always_ff @(posedge clk_i) begin
    if (wr_en_s) begin
      valid_mem_r[wr_ptr_r] <= valids_i;
      uop_mem_r[wr_ptr_r]   <= uops_i;
    end
  end

  // Head presentation, forced to zero while empty so stale storage never leaks out.
  always_comb begin
    ivalids_o = {NrRetiredInstr{1'b0}};
    uop_a_o   = UopZero;
    uop_b_o   = UopZero;
    uop_c_o   = UopZero;
    uop_d_o   = UopZero;
    if (!empty_s) begin
      ivalids_o = valid_mem_r[rd_ptr_r];
      uop_a_o   = uop_mem_r[rd_ptr_r][0];
      uop_b_o   = uop_mem_r[rd_ptr_r][1];
      uop_c_o   = uop_mem_r[rd_ptr_r][2];
      uop_d_o   = uop_mem_r[rd_ptr_r][3];
    end else begin
      ivalids_o = {NrRetiredInstr{1'b0}};
    end
  end

  assign empty_o    = empty_s;
  assign full_o     = full_s;
  assign count_o    = count_r;
  assign overflow_o = overflow_r;

endmodule

// File: tb/tb_ingress_bundle_fifo.sv
// Directed and seeded-random checks of the ingress bundle FIFO against hand-derived
// expectations and a reference queue of bundle seeds.
module tb_ingress_bundle_fifo;
  import mure_pkg::*;

  logic                            clk_i;
  logic                            rst_ni;
  logic [NrRetiredInstr-1:0]       valids_i;
  uop_entry_s [NrRetiredInstr-1:0] uops_i;
  logic                            flush_i;
  logic                            pop_i;
  logic [NrRetiredInstr-1:0]       ivalids_o;
  uop_entry_s                      uop_a_o;
  uop_entry_s                      uop_b_o;
  uop_entry_s                      uop_c_o;
  uop_entry_s                      uop_d_o;
  logic                            empty_o;
  logic                            full_o;
  logic [3:0]                      count_o;
  logic                            overflow_o;

  int checks = 0;
  int errors = 0;

  ingress_bundle_fifo #(.Depth(8)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .valids_i(valids_i), .uops_i(uops_i),
    .flush_i(flush_i), .pop_i(pop_i), .ivalids_o(ivalids_o),
    .uop_a_o(uop_a_o), .uop_b_o(uop_b_o), .uop_c_o(uop_c_o), .uop_d_o(uop_d_o),
    .empty_o(empty_o), .full_o(full_o), .count_o(count_o), .overflow_o(overflow_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  function automatic uop_entry_s [NrRetiredInstr-1:0] mk_uops(input int seed);
    uop_entry_s [NrRetiredInstr-1:0] u;
    for (int i = 0; i < NrRetiredInstr; i++) begin
      u[i].pc    = 32'(seed * 256 + i * 4);
      u[i].itype = itype_e'(3'((seed + i) % 7));
      u[i].rd    = 5'(seed + i);
    end
    return u;
  endfunction

  function automatic logic [NrRetiredInstr-1:0] mk_valids(input int seed);
    return {1'b1, 3'(seed)};
  endfunction

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    #3;
    checks++;
    if ({empty_o, full_o, count_o, overflow_o} !== {1'b1, 1'b0, 4'd0, 1'b0}) begin
      errors++;
      $display("FAIL reset_flags: got e=%b f=%b c=%0d o=%b, want e=1 f=0 c=0 o=0",
               empty_o, full_o, count_o, overflow_o);
    end
    checks++;
    if ({ivalids_o, uop_a_o, uop_b_o, uop_c_o, uop_d_o} !== '0) begin
      errors++;
      $display("FAIL reset_head: got v=%b a=%h, want all zero", ivalids_o, uop_a_o);
    end
    rst_ni = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    uop_entry_s [NrRetiredInstr-1:0] u;
    u = mk_uops(1);
    u[0].itype = STD;
    valids_i = 4'b1100;
    uops_i   = u;
    tick();
    valids_i = 4'b0000;
    checks++;
    if (ivalids_o !== 4'b1100 || count_o !== 4'd1) begin
      errors++;
      $display("FAIL basic_push: got v=%b c=%0d, want v=1100 c=1", ivalids_o, count_o);
    end
    checks++;
    if ({uop_a_o, uop_b_o, uop_c_o, uop_d_o} !== {u[0], u[1], u[2], u[3]} || uop_a_o.itype !== STD) begin
      errors++;
      $display("FAIL basic_uops: got a=%h d=%h, want a=%h d=%h", uop_a_o, uop_d_o, u[0], u[3]);
    end
    pop_i = 1'b1;
    tick();
    pop_i = 1'b0;
    checks++;
    if (empty_o !== 1'b1 || count_o !== 4'd0 ||
        {ivalids_o, uop_a_o, uop_b_o, uop_c_o, uop_d_o} !== '0) begin
      errors++;
      $display("FAIL basic_pop: got e=%b c=%0d v=%b a=%h, want e=1 c=0 zero head",
               empty_o, count_o, ivalids_o, uop_a_o);
    end
  endtask

  task automatic test_full_overflow();
    for (int s = 10; s < 18; s++) begin
      valids_i = mk_valids(s);
      uops_i   = mk_uops(s);
      tick();
    end
    checks++;
    if (full_o !== 1'b1 || count_o !== 4'd8 || overflow_o !== 1'b0) begin
      errors++;
      $display("FAIL fill_full: got f=%b c=%0d o=%b, want f=1 c=8 o=0", full_o, count_o, overflow_o);
    end
    valids_i = mk_valids(99);
    uops_i   = mk_uops(99);
    tick();
    valids_i = 4'b0000;
    checks++;
    if (overflow_o !== 1'b1 || count_o !== 4'd8) begin
      errors++;
      $display("FAIL overflow_drop: got o=%b c=%0d, want o=1 c=8", overflow_o, count_o);
    end
    checks++;
    if (ivalids_o !== mk_valids(10) || uop_a_o !== mk_uops(10)[0]) begin
      errors++;
      $display("FAIL overflow_head: got v=%b a=%h, want v=%b a=%h",
               ivalids_o, uop_a_o, mk_valids(10), mk_uops(10)[0]);
    end
  endtask

  task automatic test_full_push_pop();
    int exp_seed [8];
    uop_entry_s [NrRetiredInstr-1:0] e;
    for (int k = 0; k < 7; k++) exp_seed[k] = 11 + k;
    exp_seed[7] = 50;
    valids_i = mk_valids(50);
    uops_i   = mk_uops(50);
    pop_i    = 1'b1;
    tick();
    valids_i = 4'b0000;
    pop_i    = 1'b0;
    checks++;
    if (count_o !== 4'd8 || full_o !== 1'b1) begin
      errors++;
      $display("FAIL full_pushpop_count: got c=%0d f=%b, want c=8 f=1", count_o, full_o);
    end
    for (int k = 0; k < 8; k++) begin
      e = mk_uops(exp_seed[k]);
      checks++;
      if (ivalids_o !== mk_valids(exp_seed[k]) ||
          {uop_a_o, uop_b_o, uop_c_o, uop_d_o} !== {e[0], e[1], e[2], e[3]}) begin
        errors++;
        $display("FAIL drain_order[%0d]: got v=%b a=%h, want v=%b a=%h",
                 k, ivalids_o, uop_a_o, mk_valids(exp_seed[k]), e[0]);
      end
      pop_i = 1'b1;
      tick();
      pop_i = 1'b0;
    end
    checks++;
    if (empty_o !== 1'b1 || overflow_o !== 1'b1) begin
      errors++;
      $display("FAIL drain_end: got e=%b o=%b, want e=1 o=1 (sticky)", empty_o, overflow_o);
    end
  endtask

  task automatic test_zero_valids();
    valids_i = 4'b0000;
    uops_i   = mk_uops(7);
    for (int k = 0; k < 5; k++) begin
      pop_i = k[0];
      tick();
      checks++;
      if (count_o !== 4'd0 || empty_o !== 1'b1 || ivalids_o !== 4'b0000) begin
        errors++;
        $display("FAIL zero_valids[%0d]: got c=%0d e=%b v=%b, want c=0 e=1 v=0000",
                 k, count_o, empty_o, ivalids_o);
      end
    end
    pop_i = 1'b0;
  endtask

  task automatic test_flush();
    for (int s = 20; s < 23; s++) begin
      valids_i = mk_valids(s);
      uops_i   = mk_uops(s);
      tick();
    end
    checks++;
    if (count_o !== 4'd3) begin
      errors++;
      $display("FAIL flush_prefill: got c=%0d, want c=3", count_o);
    end
    flush_i  = 1'b1;
    pop_i    = 1'b1;
    valids_i = mk_valids(25);
    uops_i   = mk_uops(25);
    tick();
    flush_i  = 1'b0;
    pop_i    = 1'b0;
    valids_i = 4'b0000;
    checks++;
    if (count_o !== 4'd0 || empty_o !== 1'b1 || overflow_o !== 1'b0 || ivalids_o !== 4'b0000) begin
      errors++;
      $display("FAIL flush: got c=%0d e=%b o=%b v=%b, want c=0 e=1 o=0 v=0000",
               count_o, empty_o, overflow_o, ivalids_o);
    end
    valids_i = mk_valids(30);
    uops_i   = mk_uops(30);
    tick();
    valids_i = 4'b0000;
    checks++;
    if (count_o !== 4'd1 || ivalids_o !== mk_valids(30) || uop_d_o !== mk_uops(30)[3]) begin
      errors++;
      $display("FAIL post_flush_push: got c=%0d v=%b d=%h, want c=1 v=%b d=%h",
               count_o, ivalids_o, uop_d_o, mk_valids(30), mk_uops(30)[3]);
    end
    pop_i = 1'b1;
    tick();
    pop_i = 1'b0;
  endtask

  task automatic test_random_wrap();
    int q[$];
    bit push;
    bit pop;
    bit pop_eff;
    uop_entry_s [NrRetiredInstr-1:0] e;
    for (int cyc = 0; cyc < 20; cyc++) begin
      push     = (cyc < 9) ? 1'b1 : ($urandom_range(0, 3) != 0);
      pop      = 1'(($urandom_range(0, 1)));
      valids_i = push ? mk_valids(100 + cyc) : 4'b0000;
      uops_i   = mk_uops(100 + cyc);
      pop_i    = pop;
      tick();
      pop_eff = pop && (q.size() > 0);
      if (push && (q.size() < 8 || pop_eff)) begin
        if (pop_eff) void'(q.pop_front());
        q.push_back(100 + cyc);
      end else if (pop_eff) begin
        void'(q.pop_front());
      end
      checks++;
      if (count_o !== 4'(q.size())) begin
        errors++;
        $display("FAIL rand_count[%0d]: got c=%0d, want c=%0d", cyc, count_o, q.size());
      end
      if (q.size() > 0) begin
        e = mk_uops(q[0]);
        checks++;
        if (ivalids_o !== mk_valids(q[0]) ||
            {uop_a_o, uop_b_o, uop_c_o, uop_d_o} !== {e[0], e[1], e[2], e[3]}) begin
          errors++;
          $display("FAIL rand_head[%0d]: got v=%b a=%h, want v=%b a=%h",
                   cyc, ivalids_o, uop_a_o, mk_valids(q[0]), e[0]);
        end
      end
      if (cyc == 12) begin
        #2;
        rst_ni = 1'b0;
        #1;
        checks++;
        if ({empty_o, full_o, count_o, overflow_o} !== {1'b1, 1'b0, 4'd0, 1'b0} ||
            {ivalids_o, uop_a_o, uop_b_o, uop_c_o, uop_d_o} !== '0) begin
          errors++;
          $display("FAIL async_reset: got e=%b f=%b c=%0d o=%b v=%b, want e=1 f=0 c=0 o=0 zero head",
                   empty_o, full_o, count_o, overflow_o, ivalids_o);
        end
        #1;
        rst_ni = 1'b1;
        q.delete();
      end
    end
    valids_i = 4'b0000;
    pop_i    = 1'b0;
  endtask

  initial begin
    rst_ni   = 1'b0;
    valids_i = 4'b0000;
    uops_i   = '0;
    flush_i  = 1'b0;
    pop_i    = 1'b0;
    test_reset();
    test_basic();
    test_full_overflow();
    test_full_push_pop();
    test_zero_valids();
    test_flush();
    test_random_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
